// File: rtl/controlador_demux_pkg.sv
// Shared definitions for the demux packet sequencer: state encoding,
// default header geometry and watchdog length.
package controlador_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int DEF_DATA_BITS      = 32;
    localparam int DEF_LEN_BITS       = 8;
    localparam int DEF_CNT_BITS       = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;

    // Header: destination in the MSB, payload length in the low LEN_BITS.
    function automatic int hdr_dest_bit(input int data_bits);
        return data_bits - 1;
    endfunction

endpackage

// File: rtl/controlador_demux_if.sv
// Stream-in / demux-out bundle. slave = the sequencer, master = the
// surrounding receive path and the two destinations.
interface controlador_demux_if #(
    parameter int DATA_BITS = 32
) ();
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 sel;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid1;
    logic                 out_valid2;
    logic                 out_ready1;
    logic                 out_ready2;

    modport slave (
        input  in_data, in_valid, out_ready1, out_ready2,
        output in_ready, sel, out_data, out_valid1, out_valid2
    );

    modport master (
        output in_data, in_valid, out_ready1, out_ready2,
        input  in_ready, sel, out_data, out_valid1, out_valid2
    );
endinterface

// File: rtl/controlador_demux_watchdog_timer.sv
// Idle-cycle watchdog: counts enabled cycles, pulses expire_o combinationally
// on the TIMEOUT_CYCLES-th one, then restarts.
module watchdog_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q;

    assign expire_o = enable_i && !clear_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear_i || expire_o) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/controlador_demux.sv
// Packet sequencer for the two-output demux: routes each packet's payload to
// one destination, holds sel for the packet and aborts stalled packets.
//
//   state    | meaning
//   ST_IDLE  | waiting for a header word
//   ST_ROUTE | forwarding payload words, watchdog armed
//   ST_FLUSH | input closed, draining the held output word
module controlador_demux
    import controlador_demux_pkg::*;
#(
    parameter int DATA_BITS      = DEF_DATA_BITS,
    parameter int LEN_BITS       = DEF_LEN_BITS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_BITS       = DEF_CNT_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    controlador_demux_if.slave  bus,
    output logic                busy,
    output logic                err_timeout,
    output logic [CNT_BITS-1:0] pkt_count1,
    output logic [CNT_BITS-1:0] pkt_count2
);
    state_t                state_q;
    logic                  sel_q;
    logic                  ov_q;
    logic                  up_q;
    logic                  err_q;
    logic                  abort_q;
    logic [DATA_BITS-1:0]  data_q;
    logic [LEN_BITS-1:0]   rem_q;
    logic [CNT_BITS-1:0]   cnt1_q, cnt2_q;
    logic [CNT_BITS-1:0]   cnt1_d, cnt2_d;

    logic                  rd, in_ready_c, xfer_in, out_xfer;
    logic                  hdr_dest, hdr_zero, flush_done, inc1, inc2;
    logic [LEN_BITS-1:0]   hdr_len;
    logic                  wd_clear, wd_en, wd_expire;

    assign rd       = sel_q ? bus.out_ready2 : bus.out_ready1;
    assign hdr_dest = bus.in_data[hdr_dest_bit(DATA_BITS)];
    assign hdr_len  = bus.in_data[LEN_BITS-1:0];

    // up_q keeps in_ready low until the first clock after reset release.
    always_comb begin
        in_ready_c = 1'b0;
        case (state_q)
            ST_IDLE:  in_ready_c = up_q;
            ST_ROUTE: in_ready_c = !ov_q || rd;
            default:  in_ready_c = 1'b0;
        endcase
    end

    assign xfer_in  = bus.in_valid && in_ready_c;
    assign out_xfer = ov_q && rd;

    assign hdr_zero   = (state_q == ST_IDLE) && xfer_in && (hdr_len == '0);
    assign flush_done = (state_q == ST_FLUSH) && !ov_q && !abort_q;
    assign inc1       = (hdr_zero && !hdr_dest) || (flush_done && !sel_q);
    assign inc2       = (hdr_zero &&  hdr_dest) || (flush_done &&  sel_q);
    assign cnt1_d     = inc1 ? cnt1_q + 1'b1 : cnt1_q;
    assign cnt2_d     = inc2 ? cnt2_q + 1'b1 : cnt2_q;

    // Output backpressure holds in_ready low, so it never ages the watchdog.
    assign wd_clear = (state_q != ST_ROUTE) || xfer_in;
    assign wd_en    = (state_q == ST_ROUTE) && in_ready_c && !bus.in_valid;

    watchdog_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (wd_clear),
        .enable_i (wd_en),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            ov_q    <= 1'b0;
            up_q    <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            data_q  <= '0;
            rem_q   <= '0;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
        end else begin
            up_q   <= 1'b1;
            err_q  <= 1'b0;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;

            if (xfer_in && (state_q == ST_ROUTE)) begin
                data_q <= bus.in_data;
                ov_q   <= 1'b1;
            end else if (out_xfer) begin
                ov_q   <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (xfer_in) begin
                        sel_q   <= hdr_dest;
                        rem_q   <= hdr_len;
                        abort_q <= 1'b0;
                        if (hdr_len != '0) state_q <= ST_ROUTE;
                    end
                end
                ST_ROUTE: begin
                    if (xfer_in) begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == LEN_BITS'(1)) state_q <= ST_FLUSH;
                    end else if (wd_expire) begin
                        err_q   <= 1'b1;
                        abort_q <= 1'b1;
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!ov_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.sel        = sel_q;
    assign bus.out_data   = data_q;
    assign bus.out_valid1 = ov_q && !sel_q;
    assign bus.out_valid2 = ov_q &&  sel_q;
    assign busy           = (state_q != ST_IDLE);
    assign err_timeout    = err_q;
    assign pkt_count1     = cnt1_q;
    assign pkt_count2     = cnt2_q;
endmodule

// File: tb/tb_controlador_demux.sv
// Directed bench for controlador_demux with a 16-cycle watchdog.
module tb_controlador_demux;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int TO = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          busy, err_timeout;
    logic [CW-1:0] pkt_count1, pkt_count2;

    controlador_demux_if #(.DATA_BITS(DW)) intf ();

    controlador_demux #(
        .DATA_BITS(DW), .LEN_BITS(LW), .TIMEOUT_CYCLES(TO), .CNT_BITS(CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (intf.slave),
        .busy        (busy),
        .err_timeout (err_timeout),
        .pkt_count1  (pkt_count1),
        .pkt_count2  (pkt_count2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Downstream monitor: a transfer is seen at the negedge before its edge.
    logic [DW-1:0] q1[$], q2[$];
    int            t1[$];
    int            cyc = 0, v1_cnt = 0, v2_cnt = 0, err_cnt = 0, sel_bad = 0;
    logic          prev_ov = 1'b0, prev_sel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ov = 1'b0;
        end else begin
            if (intf.out_valid1) v1_cnt++;
            if (intf.out_valid2) v2_cnt++;
            if (err_timeout) err_cnt++;
            if (intf.out_valid1 && intf.out_ready1) begin q1.push_back(intf.out_data); t1.push_back(cyc); end
            if (intf.out_valid2 && intf.out_ready2) q2.push_back(intf.out_data);
            if (prev_ov && (intf.sel !== prev_sel)) sel_bad++;
            prev_ov  = intf.out_valid1 | intf.out_valid2;
            prev_sel = intf.sel;
        end
    end

    function automatic logic [DW-1:0] hdr(input logic dest, input logic [LW-1:0] n);
        logic [DW-1:0] h;
        h = '0;
        h[DW-1] = dest;
        h[LW-1:0] = n;
        h[LW+3:LW] = 4'hA;   // ignored field bits
        return h;
    endfunction

    task automatic send_word(input logic [DW-1:0] d, input string tag);
        bit ok = 0;
        intf.in_data  = d;
        intf.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (intf.in_ready) begin ok = 1; break; end
        end
        if (!ok) chk({tag, "_xfer_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk({tag, "_idle_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        q1.delete(); q2.delete(); t1.delete();
        v1_cnt = 0; v2_cnt = 0; err_cnt = 0;
    endtask

    int  err_at, c1, c2;
    logic seen;

    initial begin
        intf.in_data = '0; intf.in_valid = 1'b0;
        intf.out_ready1 = 1'b1; intf.out_ready2 = 1'b1;
        #3;
        chk("rst_in_ready", intf.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", intf.sel, 0);
        chk("rst_ov", {intf.out_valid1, intf.out_valid2}, 0);
        chk("rst_data", intf.out_data, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_cnt", {pkt_count1, pkt_count2}, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // dest=0, N=3, back-to-back payload
        clear_mon();
        send_word(hdr(0, 3), "t1h");
        send_word(32'hA0A0_0001, "t1a");
        send_word(32'hB0B0_0002, "t1b");
        send_word(32'hC0C0_0003, "t1c");
        intf.in_valid = 1'b0;
        @(negedge clk); chk("t1_busy_c_out", busy, 1);
        @(negedge clk); chk("t1_busy_flush", busy, 1);
        @(negedge clk); chk("t1_busy_fall", busy, 0);
        chk("t1_pkt1", pkt_count1, 1);
        chk("t1_n", q1.size(), 3);
        if (q1.size() == 3) begin
            chk("t1_w0", q1[0], 32'hA0A0_0001);
            chk("t1_w1", q1[1], 32'hB0B0_0002);
            chk("t1_w2", q1[2], 32'hC0C0_0003);
            chk("t1_consec", t1[2] - t1[0], 2);
        end
        chk("t1_no_v2", v2_cnt, 0);
        @(posedge clk); #1;

        // dest=1, N=2 with destination 2 stalled
        clear_mon();
        intf.out_ready2 = 1'b0;
        send_word(hdr(1, 2), "t2h");
        send_word(32'h2222_0001, "t2a");
        intf.in_data = 32'h2222_0002; intf.in_valid = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); seen |= intf.in_ready; end
        chk("t2_bp_in_ready", seen, 0);
        @(posedge clk); #1 intf.out_ready2 = 1'b1;
        send_word(32'h2222_0002, "t2b");
        intf.in_valid = 1'b0;
        wait_idle("t2");
        chk("t2_n", q2.size(), 2);
        if (q2.size() == 2) begin
            chk("t2_w0", q2[0], 32'h2222_0001);
            chk("t2_w1", q2[1], 32'h2222_0002);
        end
        chk("t2_no_v1", v1_cnt, 0);
        chk("t2_no_err", err_cnt, 0);
        chk("t2_pkt2", pkt_count2, 1);

        // zero-length header to dest=1
        clear_mon();
        send_word(hdr(1, 0), "t3h");
        intf.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_busy", busy, 0);
        chk("t3_pkt2", pkt_count2, 2);
        chk("t3_no_ov", v1_cnt + v2_cnt, 0);
        @(posedge clk); #1;

        // dest=0, N=4, stall after two words -> watchdog abort
        clear_mon();
        send_word(hdr(0, 4), "t4h");
        send_word(32'h4444_0001, "t4a");
        send_word(32'h4444_0002, "t4b");
        intf.in_valid = 1'b0;
        err_at = -1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (err_timeout && err_at < 0) err_at = k;
        end
        chk("t4_err_cnt", err_cnt, 1);
        chk("t4_err_at", err_at, TO);
        wait_idle("t4");
        chk("t4_n", q1.size(), 2);
        if (q1.size() == 2) chk("t4_w1", q1[1], 32'h4444_0002);
        chk("t4_pkt1", pkt_count1, 1);

        // back-to-back single-word packets, dest 0 then dest 1
        clear_mon();
        sel_bad = 0;
        send_word(hdr(0, 1), "t5h0");
        send_word(32'h5555_0000, "t5x");
        send_word(hdr(1, 1), "t5h1");
        send_word(32'h5555_0001, "t5y");
        intf.in_valid = 1'b0;
        wait_idle("t5");
        chk("t5_sel_stable", sel_bad, 0);
        chk("t5_n1", q1.size(), 1);
        chk("t5_n2", q2.size(), 1);
        if (q1.size() == 1) chk("t5_x", q1[0], 32'h5555_0000);
        if (q2.size() == 1) chk("t5_y", q2[0], 32'h5555_0001);
        chk("t5_cnts", {pkt_count1, pkt_count2}, {16'd2, 16'd3});

        // async reset mid-packet with a held word
        clear_mon();
        intf.out_ready1 = 1'b0;
        send_word(hdr(0, 3), "t6h");
        send_word(32'h6666_0001, "t6a");
        intf.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_pre_ov", intf.out_valid1, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ov", intf.out_valid1, 0);
        chk("t6_rst_data", intf.out_data, 0);
        chk("t6_rst_rdy", intf.in_ready, 0);
        chk("t6_rst_cnt", {pkt_count1, pkt_count2}, 0);
        @(posedge clk); #1 reset_n = 1'b1; intf.out_ready1 = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        send_word(hdr(1, 1), "t6h2");
        send_word(32'h6666_00FF, "t6z");
        intf.in_valid = 1'b0;
        wait_idle("t6");
        chk("t6_n2", q2.size(), 1);
        if (q2.size() == 1) chk("t6_z", q2[0], 32'h6666_00FF);
        chk("t6_n1", q1.size(), 0);
        chk("t6_pkt2", pkt_count2, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
